// File: rtl/pu_or1k_spr_gpr_initiator.sv
// Debug-side initiator for the SPR-bus GPR window: stalls the core, performs one
// SPR access to the register-file responder and returns the read data or a timeout error.
module pu_or1k_spr_gpr_initiator #(
    parameter int GPR_IDX_WIDTH        = 5,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [GPR_IDX_WIDTH-1:0]        req_gpr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] req_dat_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_o,
    output logic                            rsp_err_o,
    output logic                            stall_req_o,
    input  logic                            stalled_i,
    output logic [15:0]                     spr_bus_addr_o,
    output logic                            spr_bus_stb_o,
    output logic                            spr_bus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic                            spr_gpr_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

    localparam int OW    = OPTION_OPERAND_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     we_q, we_d;
    logic [GPR_IDX_WIDTH-1:0] gpr_q, gpr_d;
    logic [OW-1:0]            wdat_q, wdat_d;
    logic [OW-1:0]            rsp_dat_q, rsp_dat_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [8:0]               gpr_ext;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        gpr_d     = gpr_q;
        wdat_d    = wdat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    gpr_d   = req_gpr_i;
                    wdat_d  = req_dat_i;
                    cnt_d   = '0;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (stalled_i) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final allowed cycle still counts as success.
                if (spr_gpr_ack_i) begin
                    rsp_dat_d = we_q ? '0 : spr_gpr_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            default: begin
                if (rsp_ready_i) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            gpr_q     <= '0;
            wdat_q    <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            gpr_q     <= gpr_d;
            wdat_q    <= wdat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        gpr_ext                      = '0;
        gpr_ext[GPR_IDX_WIDTH-1:0]   = gpr_q;
    end

    // Bus fields are gated by the strobe so the bus reads all-zero outside an access.
    assign spr_bus_stb_o  = (state_q == ST_ACCESS);
    assign spr_bus_addr_o = spr_bus_stb_o ? {7'h02, gpr_ext} : '0;
    assign spr_bus_we_o   = spr_bus_stb_o & we_q;
    assign spr_bus_dat_o  = spr_bus_stb_o ? wdat_q : '0;
    assign req_ready_o    = (state_q == ST_IDLE);
    assign stall_req_o    = (state_q != ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;

endmodule
